// File: rtl/packet_filter_regs_mc_pkg.sv
// Shared constants, FSM states and address-decode helpers for the multi-channel packet-filter register file.
package packet_filter_regs_pkg;

  localparam int CH_STRIDE = 32'h20;

  localparam logic [4:0] OFF_STATUS    = 5'h00;
  localparam logic [4:0] OFF_CONTROL   = 5'h04;
  localparam logic [4:0] OFF_INST_LOW  = 5'h08;
  localparam logic [4:0] OFF_INST_HIGH = 5'h0C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  typedef enum logic [1:0] {SEL_STATUS, SEL_CONTROL, SEL_INST_LOW, SEL_INST_HIGH} reg_sel_t;

  typedef struct packed {
    logic     hit;
    logic [2:0] ch;
    reg_sel_t sel;
  } dec_t;

  // in_win says the channel-relative address lies below NUM_CH*CH_STRIDE.
  function automatic dec_t decode_off(input logic in_win, input logic [7:0] rel);
    dec_t d;
    d.hit = in_win;
    d.ch  = rel[7:5];
    d.sel = SEL_STATUS;
    case (rel[4:0])
      OFF_STATUS:    d.sel = SEL_STATUS;
      OFF_CONTROL:   d.sel = SEL_CONTROL;
      OFF_INST_LOW:  d.sel = SEL_INST_LOW;
      OFF_INST_HIGH: d.sel = SEL_INST_HIGH;
      default:       d.hit = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/packet_filter_regs_mc_if.sv
// AXI4-Lite bus bundle (32-bit data) between the PS interconnect and the packet-filter register file.
interface packet_filter_regs_mc_if #(parameter int AXI_ADDR_WIDTH = 32);
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [31:0]               wdata;
  logic [3:0]                wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [31:0]               rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pf_chan_regs.sv
// One filter channel: saturating clear-on-read drop counter, CONTROL, 64-bit instruction staging with valid/ready.
// PKT_FILTER_REGS_IRQ_EN adds the sticky saturation pending bit and CONTROL.irq_en.
module pf_chan_regs
  import packet_filter_regs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drop_inc_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        rd_status_i,
  input  logic        inst_ready_i,
  output logic        start_o,
  output logic [63:0] inst_data_o,
  output logic        inst_valid_o,
  output logic        hi_busy_o,
  output logic [31:0] status_o,
  output logic [31:0] control_o,
  output logic [31:0] inst_low_o,
  output logic [31:0] inst_high_o
`ifdef PKT_FILTER_REGS_IRQ_EN
  , output logic      irq_req_o
`endif
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q;
  logic [31:0]      lo_q, hi_q, hi_new;
  logic [63:0]      data_q;
  logic             valid_q;
  logic             commit;

  // A pending instruction the core is not taking this cycle blocks the commit.
  assign hi_busy_o = valid_q & ~inst_ready_i;
  assign hi_new    = apply_strb(hi_q, wdata_i, wstrb_i);
  assign commit    = wr_hi_i & ~hi_busy_o;

  always_comb begin
    cnt_d = cnt_q;
    if (rd_status_i) begin
      cnt_d = drop_inc_i ? CNT_W'(1) : '0;
    end else if (drop_inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      start_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_ctrl_i && wstrb_i[0]) start_q <= wdata_i[0];
      if (wr_lo_i) lo_q <= apply_strb(lo_q, wdata_i, wstrb_i);
      if (commit) begin
        hi_q    <= hi_new;
        data_q  <= {hi_new, lo_q};
        valid_q <= 1'b1;
      end else if (valid_q && inst_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef PKT_FILTER_REGS_IRQ_EN
  logic irq_en_q, pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      if (wr_ctrl_i && wstrb_i[0]) irq_en_q <= wdata_i[1];
      // Reaching saturation wins over a clearing STATUS read.
      if (&cnt_d)           pend_q <= 1'b1;
      else if (rd_status_i) pend_q <= 1'b0;
    end
  end

  assign irq_req_o = pend_q & irq_en_q;
  assign control_o = {30'b0, irq_en_q, start_q};
`else
  assign control_o = {31'b0, start_q};
`endif

  always_comb begin
    status_o     = 32'(cnt_q);
    status_o[31] = valid_q;
`ifdef PKT_FILTER_REGS_IRQ_EN
    status_o[30] = pend_q;
`endif
  end

  assign start_o      = start_q;
  assign inst_data_o  = data_q;
  assign inst_valid_o = valid_q;
  assign inst_low_o   = lo_q;
  assign inst_high_o  = hi_q;

endmodule

// File: rtl/packet_filter_regs_mc.sv
// AXI4-Lite register file for NUM_CH packet-filter cores: AXI write/read FSMs and address decode.
// Define PKT_FILTER_REGS_IRQ_EN to get the saturation interrupt output irq.
module packet_filter_regs_mc
  import packet_filter_regs_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASEADDR       = '0,
  parameter int                        NUM_CH         = 4,
  parameter int                        CNT_W          = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  packet_filter_regs_mc_if.slave s_axi,
  input  logic [NUM_CH-1:0]     drop_inc,
  output logic [NUM_CH-1:0]     ctrl_start,
  output logic [NUM_CH*64-1:0]  inst_data,
  output logic [NUM_CH-1:0]     inst_valid,
  input  logic [NUM_CH-1:0]     inst_ready
`ifdef PKT_FILTER_REGS_IRQ_EN
  , output logic                irq
`endif
);

  localparam logic [AXI_ADDR_WIDTH-1:0] WIN = AXI_ADDR_WIDTH'(NUM_CH * CH_STRIDE);

  wr_state_t                 wr_state_q;
  logic                      awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic [1:0]                bresp_q, wr_resp;
  logic                      aw_fire, w_fire, wr_go;

  rd_state_t                 rd_state_q;
  logic                      arready_q, rvalid_q, ar_fire;
  logic [31:0]               rdata_q, rd_word;
  logic [1:0]                rresp_q;

  logic [AXI_ADDR_WIDTH-1:0] wr_rel, rd_rel;
  dec_t                      wr_dec, rd_dec;

  logic [NUM_CH-1:0]         hi_busy;
  logic [31:0]               status_w [NUM_CH];
  logic [31:0]               control_w [NUM_CH];
  logic [31:0]               low_w [NUM_CH];
  logic [31:0]               high_w [NUM_CH];

  logic unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  assign wr_rel = awaddr_q - BASEADDR;
  assign rd_rel = s_axi.araddr - BASEADDR;
  assign wr_dec = decode_off(wr_rel < WIN, wr_rel[7:0]);
  assign rd_dec = decode_off(rd_rel < WIN, rd_rel[7:0]);

  assign aw_fire = s_axi.awvalid & awready_q;
  assign w_fire  = s_axi.wvalid & wready_q;
  assign ar_fire = s_axi.arvalid & arready_q;
  assign wr_go   = (wr_state_q == W_IDLE) & aw_held_q & w_held_q;

  always_comb begin
    wr_resp = RESP_OKAY;
    if (!wr_dec.hit) begin
      wr_resp = RESP_DECERR;
    end else if (wr_dec.sel == SEL_INST_HIGH) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_dec.ch == 3'(c) && hi_busy[c]) wr_resp = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_held_q && w_held_q) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_resp;
            wr_state_q <= W_RESP;
          end else begin
            if (aw_fire) begin
              awaddr_q  <= s_axi.awaddr;
              aw_held_q <= 1'b1;
            end
            if (w_fire) begin
              wdata_q  <= s_axi.wdata;
              wstrb_q  <= s_axi.wstrb;
              w_held_q <= 1'b1;
            end
            // Each channel stays open only until its half of the write is latched.
            awready_q <= ~(aw_held_q | aw_fire);
            wready_q  <= ~(w_held_q | w_fire);
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_dec.ch == 3'(c)) begin
        case (rd_dec.sel)
          SEL_STATUS:    rd_word = status_w[c];
          SEL_CONTROL:   rd_word = control_w[c];
          SEL_INST_LOW:  rd_word = low_w[c];
          SEL_INST_HIGH: rd_word = high_w[c];
          default:       rd_word = '0;
        endcase
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            rdata_q    <= rd_dec.hit ? rd_word : 32'h0;
            rresp_q    <= rd_dec.hit ? RESP_OKAY : RESP_DECERR;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

`ifdef PKT_FILTER_REGS_IRQ_EN
  logic [NUM_CH-1:0] irq_req;
  logic              irq_q;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) irq_q <= 1'b0;
    else            irq_q <= |irq_req;
  end

  assign irq = irq_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_here, rd_status;
    assign wr_here   = wr_go & wr_dec.hit & (wr_dec.ch == 3'(c));
    assign rd_status = ar_fire & rd_dec.hit & (rd_dec.ch == 3'(c)) & (rd_dec.sel == SEL_STATUS);

    pf_chan_regs #(.CNT_W(CNT_W)) u_chan (
      .clk          (axi_aclk),
      .rst          (axi_areset),
      .drop_inc_i   (drop_inc[c]),
      .wr_ctrl_i    (wr_here & (wr_dec.sel == SEL_CONTROL)),
      .wr_lo_i      (wr_here & (wr_dec.sel == SEL_INST_LOW)),
      .wr_hi_i      (wr_here & (wr_dec.sel == SEL_INST_HIGH)),
      .wdata_i      (wdata_q),
      .wstrb_i      (wstrb_q),
      .rd_status_i  (rd_status),
      .inst_ready_i (inst_ready[c]),
      .start_o      (ctrl_start[c]),
      .inst_data_o  (inst_data[64*c +: 64]),
      .inst_valid_o (inst_valid[c]),
      .hi_busy_o    (hi_busy[c]),
      .status_o     (status_w[c]),
      .control_o    (control_w[c]),
      .inst_low_o   (low_w[c]),
      .inst_high_o  (high_w[c])
`ifdef PKT_FILTER_REGS_IRQ_EN
      , .irq_req_o  (irq_req[c])
`endif
    );
  end

endmodule

// File: tb/tb_packet_filter_regs_mc.sv
// Directed bench for packet_filter_regs_mc (NUM_CH=4, CNT_W=4); IRQ checks only when PKT_FILTER_REGS_IRQ_EN is defined.
module tb_packet_filter_regs_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
`ifdef PKT_FILTER_REGS_IRQ_EN
  localparam logic [31:0] CTRL3_EXP  = 32'h3;
  localparam logic [31:0] STAT3_EXP  = 32'h4000000F;
`else
  localparam logic [31:0] CTRL3_EXP  = 32'h1;
  localparam logic [31:0] STAT3_EXP  = 32'h0000000F;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_filter_regs_mc_if #(.AXI_ADDR_WIDTH(32)) bus ();

  logic [NUM_CH-1:0]    drop_inc, ctrl_start, inst_valid, inst_ready;
  logic [NUM_CH*64-1:0] inst_data;
`ifdef PKT_FILTER_REGS_IRQ_EN
  logic irq;
`endif

  packet_filter_regs_mc #(
    .AXI_ADDR_WIDTH(32), .BASEADDR(32'h0), .NUM_CH(NUM_CH), .CNT_W(CNT_W)
  ) dut (
    .axi_aclk   (clk),
    .axi_areset (rst),
    .s_axi      (bus),
    .drop_inc   (drop_inc),
    .ctrl_start (ctrl_start),
    .inst_data  (inst_data),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready)
`ifdef PKT_FILTER_REGS_IRQ_EN
    , .irq      (irq)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;
  int n_tmo = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW.
  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int lead, output logic [1:0] resp, output int nb);
    int   aw_at, w_at;
    logic aw_done, w_done, aw_f, w_f;
    aw_at   = (lead < 0) ? -lead : 0;
    w_at    = (lead > 0) ? lead : 0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    resp    = 2'bxx;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    for (int t = 0; t < 40 && !(aw_done && w_done); t++) begin
      bus.awvalid = (t >= aw_at) && !aw_done;
      bus.wvalid  = (t >= w_at) && !w_done;
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw_f) aw_done = 1'b1;
      if (w_f)  w_done  = 1'b1;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) n_tmo++;
    nb = 0;
    bus.bready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      if (bus.bvalid) begin
        nb++;
        resp = bus.bresp;
      end
      @(posedge clk); #1;
    end
    bus.bready = 1'b0;
  endtask

  // pch >= 0 pulses drop_inc[pch] in the AR handshake cycle.
  task automatic axi_rd(input logic [31:0] addr, input int pch,
                        output logic [31:0] data, output logic [1:0] resp);
    logic done, f;
    done = 1'b0;
    data = 'x;
    resp = 'x;
    bus.araddr = addr;
    for (int t = 0; t < 20 && !done; t++) begin
      bus.arvalid = 1'b1;
      f = bus.arready;
      if (f && pch >= 0) drop_inc[pch] = 1'b1;
      @(posedge clk); #1;
      drop_inc = '0;
      if (f) done = 1'b1;
    end
    bus.arvalid = 1'b0;
    if (!done) n_tmo++;
    done = 1'b0;
    bus.rready = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      if (bus.rvalid) begin
        data = bus.rdata;
        resp = bus.rresp;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    if (!done) n_tmo++;
  endtask

  task automatic pulses(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      drop_inc[ch] = 1'b1;
      @(posedge clk); #1;
      drop_inc[ch] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, bs;
    int          nb;
    logic        seen;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    drop_inc = '0;
    inst_ready = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl_start", ctrl_start, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_awready", bus.awready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    rst = 1'b0;
    chk("awready_first_cycle", bus.awready, 0);
    @(posedge clk); #1;
    chk("awready_after_rst", bus.awready, 1);
    chk("arready_after_rst", bus.arready, 1);

    axi_rd(32'h04, -1, rd, rs);
    chk("rd_ch0_ctrl_data", rd, 0);
    chk("rd_ch0_ctrl_resp", rs, 0);

    axi_wr(32'h44, 32'h1, 4'hF, 3, bs, nb);
    chk("wr_aw_first_resp", bs, 0);
    chk("wr_aw_first_nb", nb, 1);
    chk("wr_aw_first_start", ctrl_start, 4'b0100);
    axi_wr(32'h44, 32'h0, 4'hF, -3, bs, nb);
    chk("wr_w_first_nb", nb, 1);
    chk("wr_w_first_start", ctrl_start, 4'b0000);
    axi_wr(32'h24, 32'h1, 4'hF, -2, bs, nb);
    chk("wr_ch1_start", ctrl_start, 4'b0010);
    axi_wr(32'h24, 32'h0, 4'b1110, 0, bs, nb);
    chk("wr_ctrl_strb_masked", ctrl_start, 4'b0010);

    pulses(1, 20);
    axi_rd(32'h20, -1, rd, rs);
    chk("drop_sat", rd, 32'hF);
    chk("drop_sat_resp", rs, 0);
    axi_rd(32'h20, -1, rd, rs);
    chk("drop_cleared", rd, 32'h0);
    axi_rd(32'h20, 1, rd, rs);
    chk("drop_rd_with_pulse", rd, 32'h0);
    axi_rd(32'h20, -1, rd, rs);
    chk("drop_after_pulse", rd, 32'h1);

    axi_wr(32'h08, 32'hDEADBEEF, 4'hF, 0, bs, nb);
    axi_wr(32'h0C, 32'h12345678, 4'hF, 0, bs, nb);
    chk("inst_commit_resp", bs, 0);
    chk("inst_data0", inst_data[63:0], 64'h12345678DEADBEEF);
    chk("inst_valid0", inst_valid, 4'b0001);
    axi_rd(32'h00, -1, rd, rs);
    chk("status_pending", rd, 32'h80000000);
    axi_wr(32'h0C, 32'hCAFEF00D, 4'hF, 0, bs, nb);
    chk("inst_busy_slverr", bs, 2'b10);
    chk("inst_busy_nb", nb, 1);
    chk("inst_busy_data", inst_data[63:0], 64'h12345678DEADBEEF);
    axi_rd(32'h0C, -1, rd, rs);
    chk("inst_high_kept", rd, 32'h12345678);
    inst_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("inst_valid_drop", inst_valid[0], 0);
    inst_ready[0] = 1'b0;
    axi_wr(32'h0C, 32'hAABBCCDD, 4'b0011, 0, bs, nb);
    chk("inst_strb_resp", bs, 0);
    chk("inst_strb_data", inst_data[63:0], 64'h1234CCDDDEADBEEF);
    inst_ready[0] = 1'b1;
    @(posedge clk); #1;
    inst_ready[0] = 1'b0;

    axi_rd(32'h80, -1, rd, rs);
    chk("rd_0x80_resp", rs, 2'b11);
    chk("rd_0x80_data", rd, 0);
    axi_rd(32'h10, -1, rd, rs);
    chk("rd_0x10_resp", rs, 2'b11);
    chk("rd_0x10_data", rd, 0);
    axi_wr(32'h80, 32'h1, 4'hF, 0, bs, nb);
    chk("wr_0x80_resp", bs, 2'b11);
    axi_wr(32'h10, 32'hFFFFFFFF, 4'hF, 1, bs, nb);
    chk("wr_0x10_resp", bs, 2'b11);
    chk("decerr_no_effect", ctrl_start, 4'b0010);

    axi_wr(32'h64, 32'h3, 4'hF, 0, bs, nb);
    chk("ch3_start", ctrl_start, 4'b1010);
    axi_rd(32'h64, -1, rd, rs);
    chk("ch3_ctrl_rd", rd, CTRL3_EXP);
    pulses(3, 16);
`ifdef PKT_FILTER_REGS_IRQ_EN
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      if (irq) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("irq_set", seen, 1);
`else
    seen = 1'b0;
`endif
    axi_rd(32'h60, -1, rd, rs);
    chk("ch3_status", rd, STAT3_EXP);
`ifdef PKT_FILTER_REGS_IRQ_EN
    repeat (2) @(posedge clk);
    #1;
    chk("irq_clear", irq, 0);
`endif

    axi_wr(32'h48, 32'h1, 4'hF, 0, bs, nb);
    axi_wr(32'h4C, 32'h2, 4'hF, 0, bs, nb);
    chk("ch2_inst_valid", inst_valid, 4'b0100);
    bus.awaddr  = 32'h04;
    bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_inst_valid", inst_valid, 0);
    chk("midrst_start", ctrl_start, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    axi_wr(32'h04, 32'h1, 4'hF, 0, bs, nb);
    chk("postrst_wr_resp", bs, 0);
    chk("postrst_wr_nb", nb, 1);
    chk("postrst_start", ctrl_start, 4'b0001);

    chk("timeouts", n_tmo, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
